execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined MIPS core. It sits directly downstream of the ALU-control decoder and consumes its 6-bit ALU operation code together with the ID/EX operands. It applies forwarding muxes, computes the ALU result and registers everything into the EX/MEM pipeline register. It supports stall (hold), flush (bubble) and a valid bit for the debug-unit step mode.

## Interface
- NB_DATA, 32, datapath width
- NB_OP_ALU, 6, ALU operation code width
- NB_REG, 5, register-address and shamt width
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = capture new EX/MEM contents; 0 = hold
- flush  in  1  1 = load a bubble into EX/MEM
- in_valid  in  1  ID/EX holds a real instruction
- alu_op  in  NB_OP_ALU  operation code from ALU-control decoder
- rs_data, rt_data  in  NB_DATA  register-file operands
- imm_ext  in  NB_DATA  sign/zero-extended immediate
- shamt  in  NB_REG  instruction shift amount
- rt_addr, rd_addr  in  NB_REG  destination candidates
- alu_src  in  1  1 = operand B is imm_ext
- reg_dst  in  1  1 = destination is rd_addr, 0 = rt_addr
- reg_write, mem_read, mem_write, mem_to_reg  in  1 each  control bits passed through
- fwd_a_sel, fwd_b_sel  in  2  00 register file, 01 ex_mem_fwd, 10 mem_wb_fwd, 11 register file
- ex_mem_fwd, mem_wb_fwd  in  NB_DATA  forwarded results
- out_valid  out  1  EX/MEM holds a real instruction
- alu_result  out  NB_DATA  registered ALU result
- store_data  out  NB_DATA  registered forwarded rt value
- write_reg  out  NB_REG  registered destination address
- zero  out  1  registered (alu_result == 0)
- out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  registered control bits

## Operation
- Forwarding: A = mux(fwd_a_sel; rs_data, ex_mem_fwd, mem_wb_fwd). Bf = mux(fwd_b_sel; rt_data, …). B = alu_src ? imm_ext : Bf. store_data source = Bf.
- ALU, combinational on alu_op:
  - 000000 SLL: Bf << shamt.
  - 000010 SRL: Bf >> shamt, logical.
  - 000011 SRA: Bf >>> shamt, arithmetic.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: same shifts as above, with amount A[4:0].
  - 100000 ADD: A + B.
  - 100011 SUB: A − B.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR: bitwise on A and B.
  - 101010 SLT: signed A < B → 1, else 0.
  - 001111 LUI: {B[15:0], 16'h0}.
  - any other code: 0.
- Arithmetic: modulo 2^NB_DATA. No overflow trap and no overflow flag; carry is discarded.
- Shifts always operate on Bf, never on the immediate. Shift amount is only the low 5 bits.
- zero is computed from the same-cycle ALU result and registered with it.
- Register update priority per rising edge: reset > flush > enable > hold.
  - reset: all outputs 0.
  - flush: out_valid and all four control outputs 0; data outputs are don't-care but are cleared to 0.
  - enable=1: capture all computed values; out_valid = in_valid; control bits are gated by in_valid (all 0 when in_valid=0).
  - enable=0: all outputs hold.

## Timing
- Reset values: every output 0, including zero (flag cleared, not computed).
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Combinational path: forwarding mux → ALU → EX/MEM register. No combinational input-to-output path.
- flush and enable=0 in the same cycle: flush wins and a bubble is loaded.
- Reset asserted mid-stall: outputs clear on the next edge. After release, the stage resumes with whatever is on its inputs.
- Forwarded values must be stable before the capturing edge. No internal forwarding of the stage's own output.

## Test plan
- Reset: hold reset 2 cycles with random inputs → all outputs 0. Release with enable=1, ADD rs=5, rt=7 → alu_result=12, zero=0, out_valid=1 one cycle later.
- Arithmetic/SLT: SUB A=3, B=5 → alu_result 0xFFFFFFFE. SLT A=0xFFFFFFFF, B=1 → 1. ADD 0xFFFFFFFF + 1 → 0, zero=1. LUI imm_ext=0x00001234, alu_src=1 → 0x12340000.
- Shifts: SRA Bf=0x80000000, shamt=4 → 0xF8000000. SRLV A=36, Bf=0x80000000 → 0x08000000 (amount 4). SLL shamt=0 → Bf unchanged.
- Forwarding: rs_data=1, ex_mem_fwd=10, fwd_a_sel=01; rt_data=2, mem_wb_fwd=20, fwd_b_sel=10, alu_src=0, ADD → alu_result=30, store_data=20. With alu_src=1, imm=4 → 14, store_data still 20.
- Stall/flush: load ADD, then enable=0 for 3 cycles with changing inputs → outputs frozen. Then flush=1 with enable=0 → out_valid=0, out_reg_write=0, out_mem_write=0.
- Bubble input and write_reg: in_valid=0, reg_write=1, mem_write=1, enable=1 → out_reg_write=0, out_mem_write=0, out_valid=0. Unknown alu_op 0x3F → alu_result 0. reg_dst=1, rd=9, rt=4 → write_reg=9; reg_dst=0 → 4.

Source files
------------

// File: rtl/execute_stage_if.sv
// EX-stage port bundle: ID/EX operands and controls in, EX/MEM register contents out.
// No storage; master drives the stage inputs, slave is the execute stage.
// Backpressure is only the enable/flush pair carried here.
interface execute_stage_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_OP_ALU = 6,
    parameter int NB_REG    = 5
);
    logic                 enable;
    logic                 flush;
    logic                 in_valid;
    logic [NB_OP_ALU-1:0] alu_op;
    logic [NB_DATA-1:0]   rs_data;
    logic [NB_DATA-1:0]   rt_data;
    logic [NB_DATA-1:0]   imm_ext;
    logic [NB_REG-1:0]    shamt;
    logic [NB_REG-1:0]    rt_addr;
    logic [NB_REG-1:0]    rd_addr;
    logic                 alu_src;
    logic                 reg_dst;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic [1:0]           fwd_a_sel;
    logic [1:0]           fwd_b_sel;
    logic [NB_DATA-1:0]   ex_mem_fwd;
    logic [NB_DATA-1:0]   mem_wb_fwd;

    logic                 out_valid;
    logic [NB_DATA-1:0]   alu_result;
    logic [NB_DATA-1:0]   store_data;
    logic [NB_REG-1:0]    write_reg;
    logic                 zero;
    logic                 out_reg_write;
    logic                 out_mem_read;
    logic                 out_mem_write;
    logic                 out_mem_to_reg;

    modport master (
        output enable, flush, in_valid, alu_op, rs_data, rt_data, imm_ext, shamt,
               rt_addr, rd_addr, alu_src, reg_dst, reg_write, mem_read, mem_write,
               mem_to_reg, fwd_a_sel, fwd_b_sel, ex_mem_fwd, mem_wb_fwd,
        input  out_valid, alu_result, store_data, write_reg, zero,
               out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg
    );

    modport slave (
        input  enable, flush, in_valid, alu_op, rs_data, rt_data, imm_ext, shamt,
               rt_addr, rd_addr, alu_src, reg_dst, reg_write, mem_read, mem_write,
               mem_to_reg, fwd_a_sel, fwd_b_sel, ex_mem_fwd, mem_wb_fwd,
        output out_valid, alu_result, store_data, write_reg, zero,
               out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: forwarding muxes, ALU, and the EX/MEM pipeline register.
// Latency 1 cycle; no combinational input-to-output path.
// enable=0 holds EX/MEM, flush loads a bubble (flush beats hold).
module execute_stage #(
    parameter int NB_DATA   = 32,
    parameter int NB_OP_ALU = 6,
    parameter int NB_REG    = 5
) (
    input logic            clock,
    input logic            reset,
    execute_stage_if.slave ex
);
    localparam logic [NB_OP_ALU-1:0] OP_SLL  = 6'b000000;
    localparam logic [NB_OP_ALU-1:0] OP_SRL  = 6'b000010;
    localparam logic [NB_OP_ALU-1:0] OP_SRA  = 6'b000011;
    localparam logic [NB_OP_ALU-1:0] OP_SLLV = 6'b000100;
    localparam logic [NB_OP_ALU-1:0] OP_SRLV = 6'b000110;
    localparam logic [NB_OP_ALU-1:0] OP_SRAV = 6'b000111;
    localparam logic [NB_OP_ALU-1:0] OP_LUI  = 6'b001111;
    localparam logic [NB_OP_ALU-1:0] OP_ADD  = 6'b100000;
    localparam logic [NB_OP_ALU-1:0] OP_SUB  = 6'b100011;
    localparam logic [NB_OP_ALU-1:0] OP_AND  = 6'b100100;
    localparam logic [NB_OP_ALU-1:0] OP_OR   = 6'b100101;
    localparam logic [NB_OP_ALU-1:0] OP_XOR  = 6'b100110;
    localparam logic [NB_OP_ALU-1:0] OP_NOR  = 6'b100111;
    localparam logic [NB_OP_ALU-1:0] OP_SLT  = 6'b101010;

    logic [NB_DATA-1:0] op_a;
    logic [NB_DATA-1:0] op_bf;
    logic [NB_DATA-1:0] op_b;
    logic [NB_REG-1:0]  var_amt;
    logic [NB_DATA-1:0] alu_res;
    logic [NB_REG-1:0]  dest_reg;

    logic               out_valid_q;
    logic [NB_DATA-1:0] alu_result_q;
    logic [NB_DATA-1:0] store_data_q;
    logic [NB_REG-1:0]  write_reg_q;
    logic               zero_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic               mem_to_reg_q;

    always_comb begin
        case (ex.fwd_a_sel)
            2'b01:   op_a = ex.ex_mem_fwd;
            2'b10:   op_a = ex.mem_wb_fwd;
            default: op_a = ex.rs_data;
        endcase
        case (ex.fwd_b_sel)
            2'b01:   op_bf = ex.ex_mem_fwd;
            2'b10:   op_bf = ex.mem_wb_fwd;
            default: op_bf = ex.rt_data;
        endcase
        op_b     = ex.alu_src ? ex.imm_ext : op_bf;
        var_amt  = op_a[NB_REG-1:0];
        dest_reg = ex.reg_dst ? ex.rd_addr : ex.rt_addr;
    end

    // Shifts always take the forwarded rt value, never the immediate.
    always_comb begin
        alu_res = '0;
        case (ex.alu_op)
            OP_SLL:  alu_res = op_bf << ex.shamt;
            OP_SRL:  alu_res = op_bf >> ex.shamt;
            OP_SRA:  alu_res = $signed(op_bf) >>> ex.shamt;
            OP_SLLV: alu_res = op_bf << var_amt;
            OP_SRLV: alu_res = op_bf >> var_amt;
            OP_SRAV: alu_res = $signed(op_bf) >>> var_amt;
            OP_LUI:  alu_res = {op_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || ex.flush) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            write_reg_q  <= '0;
            zero_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (ex.enable) begin
            out_valid_q  <= ex.in_valid;
            alu_result_q <= alu_res;
            store_data_q <= op_bf;
            write_reg_q  <= dest_reg;
            zero_q       <= (alu_res == '0);
            // A bubble in ID/EX must not commit any side effect downstream.
            reg_write_q  <= ex.reg_write  & ex.in_valid;
            mem_read_q   <= ex.mem_read   & ex.in_valid;
            mem_write_q  <= ex.mem_write  & ex.in_valid;
            mem_to_reg_q <= ex.mem_to_reg & ex.in_valid;
        end
    end

    assign ex.out_valid      = out_valid_q;
    assign ex.alu_result     = alu_result_q;
    assign ex.store_data     = store_data_q;
    assign ex.write_reg      = write_reg_q;
    assign ex.zero           = zero_q;
    assign ex.out_reg_write  = reg_write_q;
    assign ex.out_mem_read   = mem_read_q;
    assign ex.out_mem_write  = mem_write_q;
    assign ex.out_mem_to_reg = mem_to_reg_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SRLV = 6'b000110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100011;
    localparam logic [5:0] OP_SLT  = 6'b101010;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    execute_stage_if bus ();

    execute_stage dut (
        .clock (clock),
        .reset (reset),
        .ex    (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_defaults();
        bus.enable     = 1'b1;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b1;
        bus.alu_op     = OP_ADD;
        bus.rs_data    = '0;
        bus.rt_data    = '0;
        bus.imm_ext    = '0;
        bus.shamt      = '0;
        bus.rt_addr    = '0;
        bus.rd_addr    = '0;
        bus.alu_src    = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.fwd_a_sel  = 2'b00;
        bus.fwd_b_sel  = 2'b00;
        bus.ex_mem_fwd = '0;
        bus.mem_wb_fwd = '0;
    endtask

    task automatic test_reset();
        set_defaults();
        reset = 1'b1;
        bus.rs_data    = $urandom;
        bus.rt_data    = $urandom;
        bus.rd_addr    = 5'd17;
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.alu_result !== 32'h0) $display("FAIL reset_alu_result got %h expected %h", bus.alu_result, 32'h0);
        else n_pass++;
        n_checks++;
        if ({bus.out_valid, bus.zero, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg} !== 6'b0)
            $display("FAIL reset_flags got %b expected %b",
                     {bus.out_valid, bus.zero, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg}, 6'b0);
        else n_pass++;
        n_checks++;
        if (bus.store_data !== 32'h0 || bus.write_reg !== 5'd0)
            $display("FAIL reset_data got store %h reg %0d expected 0 0", bus.store_data, bus.write_reg);
        else n_pass++;

        set_defaults();
        reset = 1'b0;
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd7;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'd12 || bus.zero !== 1'b0 || bus.out_valid !== 1'b1)
            $display("FAIL first_add got res %h zero %b valid %b expected 0000000c 0 1", bus.alu_result, bus.zero, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_arith();
        set_defaults();
        bus.alu_op = OP_SUB; bus.rs_data = 32'd3; bus.rt_data = 32'd5;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'hFFFF_FFFE) $display("FAIL sub got %h expected %h", bus.alu_result, 32'hFFFF_FFFE);
        else n_pass++;

        bus.alu_op = OP_SLT; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'd1;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'd1) $display("FAIL slt_signed got %h expected %h", bus.alu_result, 32'd1);
        else n_pass++;

        bus.alu_op = OP_ADD; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'd1;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'h0 || bus.zero !== 1'b1)
            $display("FAIL add_wrap got res %h zero %b expected 00000000 1", bus.alu_result, bus.zero);
        else n_pass++;

        bus.alu_op = OP_LUI; bus.imm_ext = 32'h0000_1234; bus.alu_src = 1'b1;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'h1234_0000) $display("FAIL lui got %h expected %h", bus.alu_result, 32'h1234_0000);
        else n_pass++;
    endtask

    task automatic test_shifts();
        set_defaults();
        // Immediate selected but shift must still use rt.
        bus.alu_op = OP_SRA; bus.rt_data = 32'h8000_0000; bus.shamt = 5'd4;
        bus.alu_src = 1'b1; bus.imm_ext = 32'h0000_00FF;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'hF800_0000) $display("FAIL sra got %h expected %h", bus.alu_result, 32'hF800_0000);
        else n_pass++;

        bus.alu_op = OP_SRLV; bus.rs_data = 32'd36; bus.alu_src = 1'b0;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'h0800_0000) $display("FAIL srlv got %h expected %h", bus.alu_result, 32'h0800_0000);
        else n_pass++;

        bus.alu_op = OP_SLL; bus.rt_data = 32'hA5A5_1234; bus.shamt = 5'd0;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'hA5A5_1234) $display("FAIL sll_zero got %h expected %h", bus.alu_result, 32'hA5A5_1234);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        set_defaults();
        bus.rs_data = 32'd1;  bus.ex_mem_fwd = 32'd10; bus.fwd_a_sel = 2'b01;
        bus.rt_data = 32'd2;  bus.mem_wb_fwd = 32'd20; bus.fwd_b_sel = 2'b10;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'd30 || bus.store_data !== 32'd20)
            $display("FAIL fwd_reg got res %0d store %0d expected 30 20", bus.alu_result, bus.store_data);
        else n_pass++;

        bus.alu_src = 1'b1; bus.imm_ext = 32'd4;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'd14 || bus.store_data !== 32'd20)
            $display("FAIL fwd_imm got res %0d store %0d expected 14 20", bus.alu_result, bus.store_data);
        else n_pass++;

        bus.alu_src = 1'b0; bus.fwd_a_sel = 2'b11; bus.fwd_b_sel = 2'b11;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'd3 || bus.store_data !== 32'd2)
            $display("FAIL fwd_sel11 got res %0d store %0d expected 3 2", bus.alu_result, bus.store_data);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        set_defaults();
        bus.rs_data = 32'd100; bus.rt_data = 32'd23;
        bus.reg_write = 1'b1; bus.mem_write = 1'b1;
        bus.reg_dst = 1'b1; bus.rd_addr = 5'd12;
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rs_data   = 32'd1000 + i;
            bus.rt_data   = 32'd7 * i;
            bus.rd_addr   = 5'(i + 1);
            bus.in_valid  = i[0];
            bus.reg_write = i[0];
            tick();
            n_checks++;
            if (bus.alu_result !== 32'd123 || bus.out_valid !== 1'b1 || bus.out_reg_write !== 1'b1 ||
                bus.out_mem_write !== 1'b1 || bus.write_reg !== 5'd12 || bus.store_data !== 32'd23)
                $display("FAIL stall_hold cycle %0d got res %0d valid %b rw %b mw %b reg %0d store %0d expected 123 1 1 1 12 23",
                         i, bus.alu_result, bus.out_valid, bus.out_reg_write, bus.out_mem_write, bus.write_reg, bus.store_data);
            else n_pass++;
        end

        bus.flush = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0 || bus.out_mem_write !== 1'b0 || bus.alu_result !== 32'h0)
            $display("FAIL flush got valid %b rw %b mw %b res %h expected 0 0 0 00000000",
                     bus.out_valid, bus.out_reg_write, bus.out_mem_write, bus.alu_result);
        else n_pass++;
    endtask

    task automatic test_bubble_dest();
        set_defaults();
        bus.in_valid = 1'b0; bus.reg_write = 1'b1; bus.mem_write = 1'b1;
        bus.mem_read = 1'b1; bus.mem_to_reg = 1'b1;
        bus.rs_data = 32'd4; bus.rt_data = 32'd4;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg} !== 5'b0 ||
            bus.alu_result !== 32'd8)
            $display("FAIL bubble got flags %b res %0d expected 00000 8",
                     {bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg}, bus.alu_result);
        else n_pass++;

        set_defaults();
        bus.alu_op = 6'h3F; bus.rs_data = 32'h1234; bus.rt_data = 32'h55;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'h0 || bus.zero !== 1'b1)
            $display("FAIL unknown_op got res %h zero %b expected 00000000 1", bus.alu_result, bus.zero);
        else n_pass++;

        bus.alu_op = OP_ADD; bus.reg_dst = 1'b1; bus.rd_addr = 5'd9; bus.rt_addr = 5'd4;
        tick();
        n_checks++;
        if (bus.write_reg !== 5'd9) $display("FAIL write_reg_rd got %0d expected %0d", bus.write_reg, 9);
        else n_pass++;

        bus.reg_dst = 1'b0;
        tick();
        n_checks++;
        if (bus.write_reg !== 5'd4) $display("FAIL write_reg_rt got %0d expected %0d", bus.write_reg, 4);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        set_defaults();
        bus.rs_data = 32'd2; bus.rt_data = 32'd3; bus.reg_write = 1'b1;
        tick();
        bus.enable = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'h0 || bus.out_valid !== 1'b0 || bus.out_reg_write !== 1'b0)
            $display("FAIL reset_in_stall got res %h valid %b rw %b expected 00000000 0 0",
                     bus.alu_result, bus.out_valid, bus.out_reg_write);
        else n_pass++;

        reset = 1'b0;
        bus.enable = 1'b1; bus.rs_data = 32'd8; bus.rt_data = 32'd9;
        tick();
        n_checks++;
        if (bus.alu_result !== 32'd17 || bus.out_valid !== 1'b1 || bus.out_reg_write !== 1'b1)
            $display("FAIL resume_after_reset got res %0d valid %b rw %b expected 17 1 1",
                     bus.alu_result, bus.out_valid, bus.out_reg_write);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shifts();
        test_forwarding();
        test_stall_flush();
        test_bubble_dest();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
